// File: rtl/plugboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plugboard_pkg
// Purpose  : Shared constants, letter index type and helpers for the
//            plugboard and rotor stages.
// Revision : 1.0 - initial release
// ============================================================================
package plugboard_pkg;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam int         ALPHA   = 26;

  typedef logic [4:0] letter_idx_t;

  // Two-state controller encoding
  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_CLEAR = 1'b1;

  // True for an upper-case ASCII letter
  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

  // Alphabet index of a letter; only meaningful after is_upper() holds
  function automatic letter_idx_t to_idx(input logic [7:0] c);
    logic [7:0] diff;
    diff = c - ASCII_A;
    return diff[4:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/plugboard_stage_plug_table.sv
`default_nettype none
// ============================================================================
// Module   : plug_table
// Purpose  : 26-entry letter swap table. One pair write (a<->b), one sweep
//            write used by the clear, one combinational read, and a vector
//            flagging which letters are still unplugged.
// Revision : 1.0 - initial release
// ============================================================================
module plug_table
  import plugboard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              pair_we,
  input  letter_idx_t       pair_a,
  input  letter_idx_t       pair_b,
  input  logic              clr_we,
  input  letter_idx_t       clr_idx,
  input  letter_idx_t       rd_idx,
  output letter_idx_t       rd_data,
  output logic [ALPHA-1:0]  free
);

  letter_idx_t tbl_q [ALPHA];
  letter_idx_t tbl_d [ALPHA];

  // Next table contents: the clear sweep has priority over a pair write
  always_comb begin
    for (int i = 0; i < ALPHA; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    if (clr_we) begin
      if (clr_idx < letter_idx_t'(ALPHA)) begin
        tbl_d[clr_idx] = clr_idx;
      end
    end else if (pair_we) begin
      if ((pair_a < letter_idx_t'(ALPHA)) && (pair_b < letter_idx_t'(ALPHA))) begin
        tbl_d[pair_a] = pair_b;
        tbl_d[pair_b] = pair_a;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ALPHA; gi++) begin : g_entry
      // Each entry resets to identity
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tbl_q[gi] <= letter_idx_t'(gi);
        end else begin
          tbl_q[gi] <= tbl_d[gi];
        end
      end

      assign free[gi] = (tbl_q[gi] == letter_idx_t'(gi));
    end
  endgenerate

  // Lookup for the character path; out-of-range indices read back unchanged
  always_comb begin
    rd_data = rd_idx;
    if (rd_idx < letter_idx_t'(ALPHA)) begin
      rd_data = tbl_q[rd_idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/plugboard_stage.sv
`default_nettype none
// ============================================================================
// Module   : plugboard_stage
// Purpose  : Steckerbrett stage feeding the rotor. Swaps configured letter
//            pairs on each ASCII character with one cycle of latency, accepts
//            pair writes with conflict checking, and clears the table with a
//            fixed-length sweep.
// Revision : 1.0 - initial release
// ============================================================================
module plugboard_stage
  import plugboard_pkg::*;
#(
  parameter int MAX_PAIRS  = 10,
  parameter int CLR_CYCLES = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_clr,
  input  logic        cfg_wr,
  input  logic [7:0]  cfg_a,
  input  logic [7:0]  cfg_b,
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic [3:0]  pair_cnt,
  output logic        busy,
  input  logic        valid,
  input  logic [7:0]  din,
  output logic        ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        char_err
);

  localparam letter_idx_t K_LAST = letter_idx_t'(CLR_CYCLES - 1);

  logic [0:0]   state_q, state_d;
  letter_idx_t  k_q, k_d;
  logic [3:0]   pair_cnt_q, pair_cnt_d;
  logic         cfg_ack_q, cfg_ack_d;
  logic         cfg_err_q, cfg_err_d;
  logic [7:0]   dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;
  logic         char_err_q, char_err_d;

  logic              clr_we;
  logic              clr_last;
  logic              idle;
  logic              wr_evt;
  logic              pair_ok;
  logic              take;
  letter_idx_t       idx_a, idx_b, rd_idx, rd_data;
  logic [ALPHA-1:0]  free;

  plug_table u_table (
    .clk     (clk),
    .reset   (reset),
    .pair_we (pair_ok),
    .pair_a  (idx_a),
    .pair_b  (idx_b),
    .clr_we  (clr_we),
    .clr_idx (k_q),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .free    (free)
  );

  // Controller state and sweep counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STATE_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next state: a clear pulse starts the sweep, which ends after the last index
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      STATE_IDLE: begin
        if (cfg_clr) begin
          state_d = STATE_CLEAR;
          k_d     = '0;
        end
      end
      STATE_CLEAR: begin
        if (k_q == K_LAST) begin
          state_d = STATE_IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
    endcase
  end

  // Controller outputs: sweep write enable, busy flag and end-of-sweep marker
  always_comb begin
    clr_we   = (state_q == STATE_CLEAR);
    busy     = (state_q == STATE_CLEAR);
    clr_last = (state_q == STATE_CLEAR) && (k_q == K_LAST);
  end

  // Handshake and pair-conflict decode; cfg_clr outranks cfg_wr outranks valid
  always_comb begin
    idle    = (state_q == STATE_IDLE);
    ready   = idle && !cfg_clr && !cfg_wr;
    take    = valid && ready;
    wr_evt  = idle && cfg_wr && !cfg_clr;
    idx_a   = to_idx(cfg_a);
    idx_b   = to_idx(cfg_b);
    rd_idx  = to_idx(din);
    pair_ok = 1'b0;
    if (wr_evt && is_upper(cfg_a) && is_upper(cfg_b) && (idx_a != idx_b)) begin
      pair_ok = free[idx_a] && free[idx_b] && (pair_cnt_q < 4'(MAX_PAIRS));
    end
  end

  // Next values for the config responses, pair count and character output
  always_comb begin
    pair_cnt_d   = pair_cnt_q;
    cfg_ack_d    = pair_ok;
    cfg_err_d    = wr_evt && !pair_ok;
    dout_d       = dout_q;
    dout_valid_d = take;
    char_err_d   = 1'b0;

    if (clr_last) begin
      pair_cnt_d = '0;
    end else if (pair_ok) begin
      pair_cnt_d = pair_cnt_q + 4'd1;
    end

    if (take) begin
      if (is_upper(din)) begin
        dout_d = ASCII_A + {3'b000, rd_data};
      end else begin
        dout_d     = din;
        char_err_d = 1'b1;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_cnt_q   <= '0;
      cfg_ack_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      char_err_q   <= 1'b0;
    end else begin
      pair_cnt_q   <= pair_cnt_d;
      cfg_ack_q    <= cfg_ack_d;
      cfg_err_q    <= cfg_err_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      char_err_q   <= char_err_d;
    end
  end

  assign pair_cnt   = pair_cnt_q;
  assign cfg_ack    = cfg_ack_q;
  assign cfg_err    = cfg_err_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign char_err   = char_err_q;

endmodule
`default_nettype wire

// File: tb/tb_plugboard_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_plugboard_stage
// Purpose  : Self-checking bench for plugboard_stage: directed scenarios with
//            literal expectations plus randomized traffic against a letter-map
//            reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plugboard_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_clr, cfg_wr, valid;
  logic [7:0] cfg_a, cfg_b, din;
  logic       cfg_ack, cfg_err, busy, ready, dout_valid, char_err;
  logic [3:0] pair_cnt;
  logic [7:0] dout;

  int checks = 0;
  int errors = 0;

  plugboard_stage #(.MAX_PAIRS(10), .CLR_CYCLES(26)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_clr    (cfg_clr),
    .cfg_wr     (cfg_wr),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .cfg_ack    (cfg_ack),
    .cfg_err    (cfg_err),
    .pair_cnt   (pair_cnt),
    .busy       (busy),
    .valid      (valid),
    .din        (din),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .char_err   (char_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: letter map + clear countdown ----------
  int         map [26];
  int         pairs;
  int         clr_left;
  logic [7:0] e_dout;
  bit         e_dv, e_ce, e_ack, e_err;
  int         ma, mb;

  function automatic bit letter(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 26; i++) map[i] = i;
      pairs = 0; clr_left = 0;
      e_dout = 8'h00; e_dv = 0; e_ce = 0; e_ack = 0; e_err = 0;
    end else begin
      e_dv = 0; e_ce = 0; e_ack = 0; e_err = 0;
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) begin
          for (int i = 0; i < 26; i++) map[i] = i;
          pairs = 0;
        end
      end else if (cfg_clr) begin
        clr_left = 26;
      end else if (cfg_wr) begin
        ma = int'(cfg_a) - 65;
        mb = int'(cfg_b) - 65;
        if (letter(cfg_a) && letter(cfg_b) && ma != mb && map[ma] == ma && map[mb] == mb && pairs < 10) begin
          map[ma] = mb; map[mb] = ma; pairs++; e_ack = 1;
        end else begin
          e_err = 1;
        end
      end else if (valid) begin
        e_dv = 1;
        if (letter(din)) e_dout = 8'(map[int'(din) - 65] + 65);
        else begin e_dout = din; e_ce = 1; end
      end
    end
  end

  // Every-cycle comparison on the falling edge
  always @(negedge clk) begin
    check("m_dout", dout, e_dout);
    check("m_dout_valid", dout_valid, e_dv);
    check("m_char_err", char_err, e_ce);
    check("m_cfg_ack", cfg_ack, e_ack);
    check("m_cfg_err", cfg_err, e_err);
    check("m_pair_cnt", pair_cnt, pairs);
    check("m_busy", busy, clr_left > 0);
    check("m_ready", ready, (clr_left == 0) && !cfg_clr && !cfg_wr);
  end

  // ---------------- directed helpers (entered at posedge+1) ----------------
  task automatic send(input logic [7:0] c, input logic [7:0] exp, input bit ce);
    int n;
    n = 0;
    valid = 1; din = c;
    #1;
    while (!ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (!ready) begin
      check("send_ready_timeout", ready, 1);
      valid = 0;
    end else begin
      @(posedge clk); #1;
      valid = 0;
      check("send_dv", dout_valid, 1);
      check("send_dout", dout, exp);
      check("send_char_err", char_err, ce);
    end
  endtask

  task automatic plug(input logic [7:0] a, input logic [7:0] b, input bit ok);
    cfg_wr = 1; cfg_a = a; cfg_b = b;
    @(posedge clk); #1;
    cfg_wr = 0;
    check("plug_ack", cfg_ack, ok);
    check("plug_err", cfg_err, !ok);
  endtask

  logic [7:0] pa [9] = '{"B", "D", "F", "H", "J", "L", "O", "Q", "S"};
  logic [7:0] pb [9] = '{"C", "E", "G", "I", "K", "N", "P", "R", "T"};
  logic [7:0] seq [3] = '{"A", "B", "C"};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1; cfg_clr = 0; cfg_wr = 0; cfg_a = 0; cfg_b = 0; valid = 0; din = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_dv", dout_valid, 0);
    check("rst_pair_cnt", pair_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ack_err", {cfg_ack, cfg_err, char_err}, 0);
    reset = 0;

    // Identity table
    send("Q", 8'h51, 0);

    // First pair and lookups
    plug("A", "M", 1);
    check("cnt_after_AM", pair_cnt, 1);
    send("A", 8'h4D, 0);
    send("M", 8'h41, 0);
    send("B", 8'h42, 0);

    // Rejections
    plug("A", "C", 0);
    check("cnt_after_AC", pair_cnt, 1);
    plug("D", "D", 0);
    plug(8'h31, "B", 0);

    // Fill to the limit, then one more
    for (int i = 0; i < 9; i++) plug(pa[i], pb[i], 1);
    check("cnt_full", pair_cnt, 10);
    plug("U", "V", 0);
    check("cnt_sat", pair_cnt, 10);
    send("B", 8'h43, 0);

    // Clear with a character held through the sweep
    cfg_clr = 1;
    @(posedge clk); #1;
    cfg_clr = 0; valid = 1; din = "A";
    n = 0;
    while (busy && n < 100) begin
      check("clr_ready_low", ready, 0);
      @(posedge clk); #1; n++;
    end
    check("clr_busy_cycles", n, 26);
    check("clr_cnt", pair_cnt, 0);
    @(posedge clk); #1;
    valid = 0;
    check("clr_held_dv", dout_valid, 1);
    check("clr_held_dout", dout, 8'h41);

    // Non-letter pass-through
    send(8'h20, 8'h20, 1);

    // Back-to-back
    valid = 1;
    for (int i = 0; i < 3; i++) begin
      din = seq[i];
      @(posedge clk); #1;
      check("b2b_dv", dout_valid, 1);
      check("b2b_dout", dout, 8'h41 + i);
    end
    valid = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      n = $urandom_range(0, 99);
      cfg_clr = (n == 0);
      cfg_wr  = (n >= 1 && n <= 8);
      cfg_a   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(65 + $urandom_range(0, 25));
      cfg_b   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(65 + $urandom_range(0, 25));
      valid   = ($urandom_range(0, 2) != 0);
      din     = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(65 + $urandom_range(0, 25));
    end
    @(posedge clk); #1;
    cfg_clr = 0; cfg_wr = 0; valid = 0;

    // Reset mid-stream
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    plug("A", "M", 1);
    valid = 1; din = "A";
    @(posedge clk); #1;
    check("mid_dv_before", dout_valid, 1);
    check("mid_dout_before", dout, 8'h4D);
    din = "B";
    reset = 1;
    #1;
    check("mid_dv_reset", dout_valid, 0);
    check("mid_dout_reset", dout, 8'h00);
    check("mid_cnt_reset", pair_cnt, 0);
    valid = 0;
    @(posedge clk); #1;
    reset = 0;
    send("A", 8'h41, 0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/plugboard_stage.md
Name: plugboard_stage

Overview:
- Steckerbrett stage directly upstream of the rotor stage: swaps configured letter pairs on each ASCII character, then hands the result to the rotor's din/valid inputs.
- Holds a 26-entry pair-swap table, written one pair at a time through a configuration port with conflict checking.
- Adds a multi-cycle table clear, a ready/valid input handshake and a registered one-cycle data path.

Parameters:
- MAX_PAIRS, 10, maximum number of simultaneously plugged pairs (1..13).
- CLR_CYCLES, 26, length of the clear sweep in cycles; fixed at the alphabet size.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_clr  input  1  start a table clear (single-cycle pulse).
- cfg_wr  input  1  request to plug pair cfg_a<->cfg_b (single-cycle pulse).
- cfg_a  input  8  ASCII letter of the pair, 'A'..'Z'.
- cfg_b  input  8  ASCII letter of the pair, 'A'..'Z'.
- cfg_ack  output  1  one-cycle pulse: pair accepted.
- cfg_err  output  1  one-cycle pulse: pair rejected.
- pair_cnt  output  4  number of pairs currently plugged.
- busy  output  1  high while CLEAR runs.
- valid  input  1  input character strobe.
- din  input  8  ASCII input character.
- ready  output  1  input accepted this cycle when valid && ready.
- dout  output  8  swapped character; feeds the rotor's din.
- dout_valid  output  1  one-cycle strobe; feeds the rotor's valid.
- char_err  output  1  qualifies dout_valid: din was not 'A'..'Z'.

Behaviour:
- Reset (asynchronous, active-high):
  - table[i] = i (identity), pair_cnt = 0, state = IDLE.
  - dout = 0x00; dout_valid, char_err, cfg_ack, cfg_err, busy = 0.
- States are IDLE and CLEAR.
  - IDLE -> CLEAR on cfg_clr.
  - CLEAR lasts exactly CLR_CYCLES cycles; a 5-bit counter k runs 0..25 and writes table[k] = k each cycle; after k = 25 the state returns to IDLE and pair_cnt = 0.
- busy = (state == CLEAR).
- ready = (state == IDLE) && !cfg_clr && !cfg_wr (combinational).
- Priority in IDLE: cfg_clr > cfg_wr > valid.
  - When cfg_clr and cfg_wr are both high, cfg_wr is dropped with no ack or err.
  - A valid that is not accepted is dropped; the upstream source must hold it until ready.
- cfg_wr or cfg_clr during CLEAR is ignored, with no ack or err.
- Config write, evaluated in the cycle cfg_wr is high in IDLE; the result is registered one cycle later.
  - Accept only if all hold: cfg_a and cfg_b in 0x41..0x5A; cfg_a != cfg_b; table[a] == a and table[b] == b (both unplugged); pair_cnt < MAX_PAIRS.
  - On accept: table[a] = b, table[b] = a, pair_cnt + 1, cfg_ack = 1 for one cycle.
  - On any failure: table unchanged, cfg_err = 1 for one cycle.
  - Re-plugging an already-plugged letter always errors; unplugging individual letters is only possible through a full clear.
- Data path, on accept (valid && ready):
  - Letter (0x41..0x5A): next cycle dout = table[din - 0x41] + 0x41, dout_valid = 1, char_err = 0.
  - Non-letter: next cycle dout = din (pass-through), dout_valid = 1, char_err = 1.
  - Latency is 1 cycle; throughput is 1 character per cycle.
  - dout holds its value after dout_valid drops.
- Table lookup happens in the accept cycle. A cfg_clr in the following cycle does not affect a character already accepted; its dout_valid still fires.
- Arithmetic: letter indices are 5-bit (din - 0x41 truncated to 5 bits after the range check). pair_cnt saturates at MAX_PAIRS by construction.
- Reset mid-CLEAR or mid-transfer: everything returns to the reset state immediately; no partial output.

Decomposition:
- Shared package:
  - ASCII_A = 8'h41, ASCII_Z = 8'h5A, ALPHA = 26.
  - letter_idx_t (5-bit) typedef.
  - is_upper() function.
  - state encoding: IDLE = 1'b0, CLEAR = 1'b1.
  - The rotor stage reuses the same constants.
- One natural sub-module, plug_table: the 26x5 register array with two write ports (pair write a/b) and one combinational read port, plus the clear-sweep write. The FSM, conflict check and data register stay in plugboard_stage.

Test Plan:
- Reset, then valid with din = 0x51 ('Q') -> next cycle dout = 0x51, dout_valid = 1, char_err = 0 (identity table).
- cfg_wr with a = 'A', b = 'M' -> cfg_ack pulse, pair_cnt = 1. Then send 'A' -> dout 0x4D; send 'M' -> dout 0x41; send 'B' -> dout 0x42.
- After A<->M is plugged, cfg_wr with A/C -> cfg_err pulse, pair_cnt stays 1. cfg_wr with D/D -> cfg_err. cfg_wr with a = 0x31 -> cfg_err.
- Plug 10 distinct pairs -> 10 acks. An 11th pair -> cfg_err, pair_cnt = 10.
- cfg_clr -> busy high for exactly 26 cycles and ready = 0 throughout; valid held during CLEAR is accepted on the first IDLE cycle. After the clear, 'A' -> 0x41 and pair_cnt = 0.
- din = 0x20 (space) -> dout = 0x20 with char_err = 1. Back-to-back 'A','B','C' on consecutive cycles -> three consecutive dout_valid strobes. Asserting reset mid-stream -> dout_valid = 0 in the same cycle and the table returns to identity.
